// File: rtl/bit_count_pkg.sv
// Shared types and helpers for the sequential bit-count engine.
// Instantiating blocks use res_width() to size the result bus they connect
// to bit_count_seq, so both sides agree on the count width.
package bit_count_pkg;

    // Operation phases of the counter.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } bc_state_t;

    // Width needed to hold a count of 0..data_w ones.
    function automatic int res_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage : bit_count_pkg

// File: rtl/popcount_slice.sv
// Combinational ones-count of a narrow slice.
// The count is produced directly at OUT_W bits so the caller can add it to
// its accumulator without any further extension.
module popcount_slice #(
    parameter int W     = 1,
    parameter int OUT_W = 4
) (
    input  logic [W-1:0]     i_slice,
    output logic [OUT_W-1:0] o_count
);

    logic [OUT_W-1:0] w_acc;

    // Sum the slice bits one at a time, each zero-extended to OUT_W.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < W; i++) begin
            w_acc = w_acc + OUT_W'(i_slice[i]);
        end
    end

    assign o_count = w_acc;

endmodule : popcount_slice

// File: rtl/bit_count_seq.sv
// Sequential population counter.
//
// A word is captured on a level start request, optionally inverted so that
// zeros are counted instead of ones, then shifted right BITS_PER_CYCLE bits
// per clock while the ones in the bottom slice are accumulated. The run ends
// as soon as the remaining shifted word is all zero, so short operands finish
// early. The result is held with done until start is released.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for start; result holds the last completed count
//   S_RUN  | consuming one slice of the shift register per clock
//   S_DONE | result valid; waiting for start to drop
//
// Any other state encoding falls back to S_IDLE with both status flags low.
module bit_count_seq
    import bit_count_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int RES_W          = res_width(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_count_zeros,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              o_busy,
    output logic              o_done,
    output logic [RES_W-1:0]  o_result
);

    // Reject parameter sets that cannot produce a whole number of slices
    // or whose result bus is not the derived width.
    generate
        if (DATA_W < 1) begin : g_bad_data_w
            $error("bit_count_seq: DATA_W must be at least 1");
        end
        if (BITS_PER_CYCLE < 1) begin : g_bad_bpc
            $error("bit_count_seq: BITS_PER_CYCLE must be at least 1");
        end
        else if ((DATA_W % BITS_PER_CYCLE) != 0) begin : g_bad_div
            $error("bit_count_seq: BITS_PER_CYCLE must divide DATA_W");
        end
        if (RES_W != res_width(DATA_W)) begin : g_bad_res_w
            $error("bit_count_seq: RES_W is derived and must not be overridden");
        end
    endgenerate

    bc_state_t          r_state;
    bc_state_t          w_state_nxt;
    logic [DATA_W-1:0]  r_sreg;
    logic [RES_W-1:0]   r_result;

    logic [DATA_W-1:0]  w_load_word;
    logic [DATA_W-1:0]  w_sreg_shr;
    logic               w_sreg_last;
    logic [RES_W-1:0]   w_slice_cnt;
    logic [RES_W-1:0]   w_result_sum;

    // Operand as it enters the shift register: inverting it turns a
    // zero-count into a plain ones-count for the rest of the datapath.
    assign w_load_word  = i_count_zeros ? ~i_data_in : i_data_in;

    // What the shift register becomes after this cycle's slice is consumed;
    // once it is empty there is nothing left to count.
    assign w_sreg_shr   = r_sreg >> BITS_PER_CYCLE;
    assign w_sreg_last  = (w_sreg_shr == '0);

    popcount_slice #(
        .W     (BITS_PER_CYCLE),
        .OUT_W (RES_W)
    ) u_popcount_slice (
        .i_slice (r_sreg[BITS_PER_CYCLE-1:0]),
        .o_count (w_slice_cnt)
    );

    // Cannot overflow: the sum of all slices is at most DATA_W.
    assign w_result_sum = r_result + w_slice_cnt;

    // State register plus the shift register and accumulator it steers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_sreg   <= '0;
            r_result <= '0;
        end
        else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sreg   <= w_load_word;
                        r_result <= '0;
                    end
                end
                S_RUN: begin
                    r_sreg   <= w_sreg_shr;
                    r_result <= w_result_sum;
                end
                default: begin
                    // S_DONE and stray encodings keep the datapath frozen so
                    // the count stays readable after the operation.
                end
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: w_state_nxt = i_start     ? S_RUN  : S_IDLE;
            S_RUN:  w_state_nxt = w_sreg_last ? S_DONE : S_RUN;
            S_DONE: w_state_nxt = i_start     ? S_DONE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore status flags decoded from the state register only.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_RUN:   o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: begin
                o_busy = 1'b0;
                o_done = 1'b0;
            end
        endcase
    end

    assign o_result = r_result;

endmodule : bit_count_seq

// File: tb/tb_bit_count_seq.sv
// Bench for bit_count_seq: an 8-bit/1-bit-per-cycle instance and a
// 16-bit/4-bit-per-cycle instance run side by side. A transaction-level model
// predicts busy/done/result every cycle; directed cases add literal checks.
module tb_bit_count_seq;

    localparam int W0  = 8;
    localparam int B0  = 1;
    localparam int W1  = 16;
    localparam int B1  = 4;
    localparam int RW0 = $clog2(W0 + 1);
    localparam int RW1 = $clog2(W1 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst0, st0, cz0, busy0, done0;
    logic [W0-1:0]   d0;
    logic [RW0-1:0]  res0;
    logic            rst1, st1, cz1, busy1, done1;
    logic [W1-1:0]   d1;
    logic [RW1-1:0]  res1;

    bit_count_seq #(.DATA_W(W0), .BITS_PER_CYCLE(B0)) u_dut8 (
        .i_clk(clk), .i_reset(rst0), .i_start(st0), .i_count_zeros(cz0),
        .i_data_in(d0), .o_busy(busy0), .o_done(done0), .o_result(res0)
    );

    bit_count_seq #(.DATA_W(W1), .BITS_PER_CYCLE(B1)) u_dut16 (
        .i_clk(clk), .i_reset(rst1), .i_start(st1), .i_count_zeros(cz1),
        .i_data_in(d1), .o_busy(busy1), .o_done(done1), .o_result(res1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: whether an operation is outstanding, how many edges have
    // passed since its capture, how many edges it needs, the loaded word and
    // the count held while idle.
    int          mw[2] = '{W0, W1};
    int          mb[2] = '{B0, B1};
    bit          m_known[2] = '{0, 0};
    bit          m_op[2];
    int          m_n[2];
    int          m_r[2];
    int          m_hold[2];
    logic [31:0] m_load[2];

    function automatic logic [31:0] lowmask(input int k);
        if (k >= 32) return '1;
        return (32'h1 << k) - 32'h1;
    endfunction

    task automatic upd(input int i, input logic r, input logic s, input logic cz,
                       input logic [31:0] d);
        int msb;
        if (r) begin
            m_known[i] = 1;
            m_op[i]    = 0;
            m_hold[i]  = 0;
        end
        else if (m_known[i]) begin
            if (m_op[i]) begin
                if (m_n[i] >= m_r[i]) begin
                    if (!s) begin
                        m_op[i]   = 0;
                        m_hold[i] = $countones(m_load[i]);
                    end
                end
                else begin
                    m_n[i]++;
                end
            end
            else if (s) begin
                m_op[i]   = 1;
                m_n[i]    = 0;
                m_load[i] = (cz ? ~d : d) & lowmask(mw[i]);
                msb = 0;
                for (int k = 0; k < mw[i]; k++) if (m_load[i][k]) msb = k;
                m_r[i] = (msb + mb[i]) / mb[i];
                if (m_r[i] < 1) m_r[i] = 1;
                m_hold[i] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_busy(input int i);
        return 32'(m_op[i] && (m_n[i] < m_r[i]));
    endfunction

    function automatic logic [31:0] exp_done(input int i);
        return 32'(m_op[i] && (m_n[i] >= m_r[i]));
    endfunction

    function automatic logic [31:0] exp_res(input int i);
        int bits;
        if (!m_op[i]) return 32'(m_hold[i]);
        bits = m_n[i] * mb[i];
        if (bits > mw[i]) bits = mw[i];
        return 32'($countones(m_load[i] & lowmask(bits)));
    endfunction

    always @(posedge clk) begin
        upd(0, rst0, st0, cz0, 32'(d0));
        upd(1, rst1, st1, cz1, 32'(d1));
    end

    always @(negedge clk) begin
        if (m_known[0]) begin
            chk("u8.busy",   32'(busy0), exp_busy(0));
            chk("u8.done",   32'(done0), exp_done(0));
            chk("u8.result", 32'(res0),  exp_res(0));
        end
        if (m_known[1]) begin
            chk("u16.busy",   32'(busy1), exp_busy(1));
            chk("u16.done",   32'(done1), exp_done(1));
            chk("u16.result", 32'(res1),  exp_res(1));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic go0(input string nm, input logic [7:0] d, input logic cz,
                       input bit scramble, input int hold, input int eb, input int er);
        int nb = 0;
        @(negedge clk);
        d0 = d; cz0 = cz; st0 = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (scramble) begin d0 = 8'hAA; cz0 = 1'b0; end
            if (busy0) nb++;
            if (done0) break;
        end
        chk({nm, ".done"},        32'(done0), 32'd1);
        chk({nm, ".busy_cycles"}, 32'(nb),    32'(eb));
        chk({nm, ".result"},      32'(res0),  32'(er));
        repeat (hold) @(negedge clk);
        chk({nm, ".done_held"},   32'(done0), 32'd1);
        st0 = 1'b0;
        @(negedge clk);
        chk({nm, ".idle_done"},   32'(done0), 32'd0);
        chk({nm, ".idle_result"}, 32'(res0),  32'(er));
    endtask

    task automatic go1(input string nm, input logic [15:0] d, input int eb, input int er);
        int nb = 0;
        @(negedge clk);
        d1 = d; cz1 = 1'b0; st1 = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (busy1) nb++;
            if (done1) break;
        end
        chk({nm, ".done"},        32'(done1), 32'd1);
        chk({nm, ".busy_cycles"}, 32'(nb),    32'(eb));
        chk({nm, ".result"},      32'(res1),  32'(er));
        st1 = 1'b0;
        @(negedge clk);
        chk({nm, ".idle_result"}, 32'(res1),  32'(er));
    endtask

    task automatic rand0(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            rst0 = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) st0 = ~st0;
            d0  = 8'($urandom);
            cz0 = 1'($urandom);
            if ($urandom_range(0, 2) == 0) d0 = d0 >> $urandom_range(0, 7);
        end
        rst0 = 1'b0; st0 = 1'b0;
    endtask

    task automatic rand1(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            rst1 = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) st1 = ~st1;
            d1  = 16'($urandom);
            cz1 = 1'($urandom);
            if ($urandom_range(0, 2) == 0) d1 = d1 >> $urandom_range(0, 15);
        end
        rst1 = 1'b0; st1 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nb, nd;
        rst0 = 1'b1; st0 = 1'b0; cz0 = 1'b0; d0 = '0;
        rst1 = 1'b1; st1 = 1'b0; cz1 = 1'b0; d1 = '0;
        repeat (2) @(negedge clk);
        chk("reset.busy",   32'(busy0), 32'd0);
        chk("reset.done",   32'(done0), 32'd0);
        chk("reset.result", 32'(res0),  32'd0);
        rst0 = 1'b0; rst1 = 1'b0;

        go0("t1_0F",    8'h0F, 1'b0, 1'b0, 3, 4, 4);
        go0("t2_00",    8'h00, 1'b0, 1'b0, 0, 1, 0);
        go0("t2_FF",    8'hFF, 1'b0, 1'b0, 0, 8, 8);
        go0("t2_80",    8'h80, 1'b0, 1'b0, 0, 8, 1);
        go0("t3_zeros", 8'h0F, 1'b1, 1'b1, 1, 8, 4);

        // One-cycle start pulse: the run still completes, done lasts one cycle.
        @(negedge clk);
        d0 = 8'h0F; cz0 = 1'b0; st0 = 1'b1;
        nb = 0; nd = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (t == 0) st0 = 1'b0;
            if (busy0) nb++;
            if (done0) nd++;
        end
        chk("t4.busy_cycles", 32'(nb),    32'd4);
        chk("t4.done_cycles", 32'(nd),    32'd1);
        chk("t4.result",      32'(res0),  32'd4);
        chk("t4.idle_busy",   32'(busy0), 32'd0);

        // Reset in the middle of a run, then an immediate re-capture.
        @(negedge clk);
        d0 = 8'h0F; st0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5.busy_before_reset", 32'(busy0), 32'd1);
        rst0 = 1'b1;
        @(negedge clk);
        chk("t5.reset_busy",   32'(busy0), 32'd0);
        chk("t5.reset_done",   32'(done0), 32'd0);
        chk("t5.reset_result", 32'(res0),  32'd0);
        rst0 = 1'b0;
        @(negedge clk);
        chk("t5.recapture_busy", 32'(busy0), 32'd1);
        for (int t = 0; t < 20; t++) begin
            if (done0) break;
            @(negedge clk);
        end
        chk("t5.done",   32'(done0), 32'd1);
        chk("t5.result", 32'(res0),  32'd4);
        st0 = 1'b0;
        @(negedge clk);

        go1("t6_F0F1", 16'hF0F1, 4, 9);
        go1("t6_0003", 16'h0003, 1, 2);

        fork
            rand0(3000);
            rand1(3000);
        join
        repeat (40) @(negedge clk);
        chk("end.idle_busy8",  32'(busy0), 32'd0);
        chk("end.idle_busy16", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bit_count_seq

// File: doc/bit_count_seq.md
Name: bit_count_seq

Overview:
- Parametrised sequential population counter. On a level `start` handshake it captures a `DATA_W`-bit word and shifts it right `BITS_PER_CYCLE` bits per clock, accumulating the count of ones (or zeros, by mode).
- It stops early once no set bits remain and holds the result with `done` until `start` drops.
- It is the general-purpose bit-count engine used by the lab datapaths that sit in front of RAM/lookup logic.

Parameters:
- DATA_W, 8: input word width; must be ≥ 1.
- BITS_PER_CYCLE, 1: bits consumed per RUN cycle; must divide `DATA_W`.
- RES_W, $clog2(DATA_W+1): result width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request: rising use begins an operation; must be held until `done` is seen.
- count_zeros  in  1  mode: 0 = count ones, 1 = count zeros; sampled only at capture.
- data_in  in  DATA_W  operand; sampled only at capture.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- result  out  RES_W  bit count; valid while `done`=1 and held until the next capture.

Behaviour:
- Single clock domain, one clock (`clk`). Reset is synchronous and active-high (`reset`); polarity and synchronicity are fixed.
- Reset values: state=IDLE, busy=0, done=0, result=0, internal shift register=0.
- Reset takes priority over everything, including mid-RUN: the next edge returns to IDLE with all state cleared.
- States: IDLE, RUN, DONE. `busy` and `done` are Moore outputs decoded from the state register only.
- IDLE:
  - If start=1 at an edge: load sreg = count_zeros ? ~data_in : data_in, clear result, go to RUN.
  - Otherwise stay in IDLE; result keeps its last value.
- RUN, each edge:
  - result <= result + popcount(sreg[BITS_PER_CYCLE-1:0]).
  - sreg <= sreg >> BITS_PER_CYCLE.
  - If (sreg >> BITS_PER_CYCLE) == 0, go to DONE; otherwise stay in RUN.
- RUN length is R = max(1, ceil((m+1)/BITS_PER_CYCLE)), where m is the index of the most-significant 1 in the loaded sreg.
  - For an all-zero loaded sreg, m = 0, so R = 1.
  - `done` is first visible after edge k+R, where k is the capture edge. Worst case R = DATA_W/BITS_PER_CYCLE.
- DONE: stay while start=1. When start=0, go to IDLE on the next edge.
- `start` falling during RUN is ignored. The operation completes, DONE lasts exactly one cycle, then the block returns to IDLE.
- `data_in` and `count_zeros` changes after capture have no effect.
- No re-trigger: a new operation needs start=0 seen in DONE or IDLE, then start=1 in IDLE.
- Arithmetic: `result` is RES_W bits wide and cannot overflow (maximum value DATA_W). The per-slice popcount is zero-extended to RES_W before the add.
- Illegal or unreachable state encodings decode to IDLE next, with busy=0 and done=0.
- Elaboration check: fail the build if DATA_W % BITS_PER_CYCLE != 0.

Decomposition:
- Package bit_count_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} bc_state_t;
  - function clog2-based RES_W helper, for use by instantiating blocks.
- Sub-module popcount_slice #(W=BITS_PER_CYCLE, OUT_W=RES_W): purely combinational ones-count of a W-bit slice, used in the RUN datapath.
- All sequential logic stays in bit_count_seq: one `always_ff` for state/sreg/result and one `always_comb` for next-state and outputs.
- Nonblocking assignments only in the sequential block.

Test Plan:
1. Defaults, reset 2 cycles, data_in=8'h0F, count_zeros=0, start held high → busy for 4 cycles, then done=1 with result=4, held while start=1. Drop start → next edge: IDLE, done=0, result still 4.
2. data_in=8'h00 → exactly 1 RUN cycle, result=0, done=1. data_in=8'hFF → 8 RUN cycles, result=8 (4'b1000, no overflow). data_in=8'h80 → 8 RUN cycles, result=1.
3. count_zeros=1, data_in=8'h0F → 8 RUN cycles, result=4. Change data_in to 8'hAA and count_zeros to 0 during RUN → result still 4.
4. data_in=8'h0F, start pulsed for 1 cycle only → RUN for 4 cycles, done high for exactly 1 cycle, then IDLE with result=4. No second operation starts.
5. Assert reset on the 3rd RUN cycle with start still high → next edge: IDLE, busy=0, done=0, result=0. Release reset with start=1 → new capture on the following edge.
6. DATA_W=16, BITS_PER_CYCLE=4, data_in=16'hF0F1 → 4 RUN cycles, result=9 (5-bit RES_W). data_in=16'h0003 → 1 RUN cycle, result=2.
